fs_corner_collector: RTL and testbench

- Hardware consumer of the FAST-9 score stage's corner stream: captures every (isCorner, refAddr, scoreValue) event into a FIFO.
- Closes each frame with a trailer record and presents records on a valid/ready read port toward the host/DMA.
- Sits directly after the score stage inside FAST9_Top, replacing simulation-only result printing with a synthesizable path.
- Counts corners lost to back-pressure.

---
 rtl/fs_pkg.sv | 26 ++
 rtl/fs_sync_fifo.sv | 75 +++++++
 rtl/fs_corner_collector.sv | 123 ++++++++++++
 tb/tb_fs_corner_collector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// -----------------------------------------------------------------------------
// fs_pkg
// Shared definitions for the FAST-9 score stage and its corner collector:
// default address/score widths, the FIFO record layout and the trailer FSM
// state type.
// -----------------------------------------------------------------------------
package fs_pkg;

  localparam int ADDR_W  = 17;
  localparam int SCORE_W = 8;

  // One FIFO record. A trailer uses addr to carry the frame's corner count.
  typedef struct packed {
    logic               last;
    logic [ADDR_W-1:0]  addr;
    logic [SCORE_W-1:0] score;
  } corner_rec_t;

  localparam int REC_W = $bits(corner_rec_t);

  typedef enum logic {
    TR_IDLE    = 1'b0,
    TR_PENDING = 1'b1
  } trailer_state_t;

endpackage

// File: rtl/fs_sync_fifo.sv
// -----------------------------------------------------------------------------
// fs_sync_fifo
// First-word-fall-through synchronous FIFO. rd_data shows the head entry
// (zero when empty). A push into a full FIFO is accepted only when a pop
// happens at the same edge.
//
// Ports:
//   clock    in   rising-edge clock
//   nReset   in   synchronous active-low reset (clears pointers and count)
//   push     in   write request
//   wr_data  in   WIDTH  data to write
//   pop      in   read request (ignored when empty)
//   rd_data  out  WIDTH  head entry, zero when empty
//   empty    out  no entries
//   full     out  DEPTH entries
//   level    out  $clog2(DEPTH)+1  occupancy
// -----------------------------------------------------------------------------
module fs_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] level
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, wr_ptr == rd_ptr; overwriting the head is safe because the
  // head leaves at this very edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity,
  // so clearing the array would add reset fan-out for nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fs_corner_collector.sv
// -----------------------------------------------------------------------------
// fs_corner_collector
// Captures FAST-9 corner events into a FWFT FIFO, closes each frame with a
// trailer record carrying the frame's accepted-corner count, and counts
// corners dropped because of back-pressure or a waiting trailer.
//
// Ports:
//   clock          in   rising-edge clock
//   nReset         in   synchronous active-low reset
//   isCorner       in   corner flagged this cycle
//   refAddr        in   ADDR_W   corner pixel address
//   scoreValue     in   SCORE_W  corner score
//   frameEnd       in   one-cycle end-of-frame pulse
//   outValid       out  record available
//   outReady       in   consumer accepts record
//   outLast        out  record is a frame trailer
//   outAddr        out  ADDR_W   corner address, or count on a trailer
//   outScore       out  SCORE_W  corner score, 0 on a trailer
//   level          out  $clog2(DEPTH)+1  FIFO occupancy
//   overflowCount  out  OVF_W    dropped corners, saturating
// -----------------------------------------------------------------------------
module fs_corner_collector
  import fs_pkg::*;
#(
  parameter  int ADDR_W  = fs_pkg::ADDR_W,
  parameter  int SCORE_W = fs_pkg::SCORE_W,
  parameter  int DEPTH   = 16,
  parameter  int OVF_W   = 16,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               isCorner,
  input  logic [ADDR_W-1:0]  refAddr,
  input  logic [SCORE_W-1:0] scoreValue,
  input  logic               frameEnd,
  output logic               outValid,
  input  logic               outReady,
  output logic               outLast,
  output logic [ADDR_W-1:0]  outAddr,
  output logic [SCORE_W-1:0] outScore,
  output logic [CNT_W-1:0]   level,
  output logic [OVF_W-1:0]   overflowCount
);

  localparam int LW = 1 + ADDR_W + SCORE_W;

  trailer_state_t     state;
  logic [ADDR_W-1:0]  frame_count;
  logic [LW-1:0]      wr_data;
  logic [LW-1:0]      rd_data;
  logic               empty;
  logic               full;
  logic               pop;
  logic               space;
  logic               trailer_push;
  logic               corner_push;
  logic               corner_drop;
  logic               push;

  assign pop      = outValid && outReady;
  assign space    = !full || pop;
  // A waiting trailer owns the write port; corners arriving meanwhile are
  // dropped so the trailer stays behind exactly its own frame's corners.
  assign trailer_push = (state == TR_PENDING) && space;
  assign corner_push  = (state == TR_IDLE) && isCorner && space;
  assign corner_drop  = isCorner && !corner_push;
  assign push         = trailer_push || corner_push;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would infer a latch.
  always_comb begin
    wr_data = {1'b0, refAddr, scoreValue};
    if (trailer_push) wr_data = {1'b1, frame_count, {SCORE_W{1'b0}}};
  end

  fs_sync_fifo #(
    .WIDTH (LW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .nReset  (nReset),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  assign outValid = !empty;
  assign {outLast, outAddr, outScore} = rd_data;

  // Trailer FSM plus frame and overflow counters.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      state         <= TR_IDLE;
      frame_count   <= '0;
      overflowCount <= '0;
    end else begin
      case (state)
        // A corner arriving with frameEnd is still pushed into this frame;
        // the trailer follows from PENDING.
        TR_IDLE: begin
          if (corner_push && (frame_count != '1)) frame_count <= frame_count + 1'b1;
          if (frameEnd) state <= TR_PENDING;
        end
        // frameEnd while already pending is ignored.
        TR_PENDING: begin
          if (trailer_push) begin
            frame_count <= '0;
            state       <= TR_IDLE;
          end
        end
        default: state <= TR_IDLE;
      endcase

      if (corner_drop && (overflowCount != '1)) overflowCount <= overflowCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_fs_corner_collector.sv
// -----------------------------------------------------------------------------
// tb_fs_corner_collector
// Scoreboard bench: a queue-based reference model predicts every record the
// collector should emit; a negedge monitor compares the DUT head against the
// oldest expected record and retires it when the DUT handshakes.
// -----------------------------------------------------------------------------
module tb_fs_corner_collector;
  import fs_pkg::*;

  localparam int DEPTH   = 16;
  localparam int OVF_W   = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int FC_MAX  = (1 << ADDR_W) - 1;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic               clock;
  logic               nReset;
  logic               isCorner;
  logic [ADDR_W-1:0]  refAddr;
  logic [SCORE_W-1:0] scoreValue;
  logic               frameEnd;
  logic               outValid;
  logic               outReady;
  logic               outLast;
  logic [ADDR_W-1:0]  outAddr;
  logic [SCORE_W-1:0] outScore;
  logic [CNT_W-1:0]   level;
  logic [OVF_W-1:0]   overflowCount;

  fs_corner_collector #(
    .ADDR_W  (ADDR_W),
    .SCORE_W (SCORE_W),
    .DEPTH   (DEPTH),
    .OVF_W   (OVF_W)
  ) dut (
    .clock         (clock),
    .nReset        (nReset),
    .isCorner      (isCorner),
    .refAddr       (refAddr),
    .scoreValue    (scoreValue),
    .frameEnd      (frameEnd),
    .outValid      (outValid),
    .outReady      (outReady),
    .outLast       (outLast),
    .outAddr       (outAddr),
    .outScore      (outScore),
    .level         (level),
    .overflowCount (overflowCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  corner_rec_t exp_q[$];
  int m_level = 0;
  bit m_pend  = 1'b0;
  int m_fc    = 0;
  int m_ovf   = 0;

  always @(posedge clock) begin
    if (!nReset) begin
      exp_q.delete();
      m_level = 0;
      m_pend  = 1'b0;
      m_fc    = 0;
      m_ovf   = 0;
    end else begin
      bit was_pend;
      bit do_pop;
      bit has_space;
      bit took_corner;
      corner_rec_t r;
      was_pend    = m_pend;
      do_pop      = (m_level > 0) && outReady;
      has_space   = (m_level < DEPTH) || do_pop;
      took_corner = 1'b0;
      if (do_pop) m_level--;
      if (was_pend && has_space) begin
        r.last = 1'b1; r.addr = ADDR_W'(m_fc); r.score = '0;
        exp_q.push_back(r);
        m_level++;
        m_fc   = 0;
        m_pend = 1'b0;
      end else if (!was_pend && isCorner && has_space) begin
        r.last = 1'b0; r.addr = refAddr; r.score = scoreValue;
        exp_q.push_back(r);
        m_level++;
        took_corner = 1'b1;
        if (m_fc < FC_MAX) m_fc++;
      end
      if (isCorner && !took_corner && m_ovf < OVF_MAX) m_ovf++;
      if (frameEnd && !was_pend) m_pend = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (mon_en) begin
      check("valid", outValid, m_level != 0);
      check("level", level, m_level);
      check("ovf", overflowCount, m_ovf);
      if (outValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rec", {outLast, outAddr, outScore}, 32'hFFFF_FFFF);
        end else begin
          check("rec", {outLast, outAddr, outScore}, exp_q[0]);
          if (outReady) void'(exp_q.pop_front());
        end
      end else begin
        check("empty_outputs", {outLast, outAddr, outScore}, 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit c, input int a, input int s, input bit fe, input bit rdy);
    isCorner   = c;
    refAddr    = ADDR_W'(a);
    scoreValue = SCORE_W'(s);
    frameEnd   = fe;
    outReady   = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    nReset = 1'b1;
    check("rst_valid", outValid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflowCount, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((level != 0 || exp_q.size() != 0) && n < 60) begin
      cyc(0, 0, 0, 0, 1);
      n++;
    end
    check("drain_level", level, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  int basic_addr[3]  = '{100, 205, 4000};
  int basic_score[3] = '{8'h3A, 8'h7F, 8'h12};

  initial begin
    nReset = 1'b0; isCorner = 1'b0; refAddr = '0; scoreValue = '0;
    frameEnd = 1'b0; outReady = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    nReset = 1'b1;
    mon_en = 1'b1;

    // Reset mid-stream, then an empty frame's trailer counts 0.
    for (int i = 0; i < 5; i++) cyc(1, 10 + i, i, 0, 0);
    check("pre_rst_level", level, 5);
    do_reset();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("zero_trailer", {outValid, outLast, outAddr, outScore}, {2'b11, 17'd0, 8'd0});
    drain();

    // Basic frame with a ready consumer.
    for (int i = 0; i < 3; i++) cyc(1, basic_addr[i], basic_score[i], 0, 1);
    cyc(0, 0, 0, 1, 1);
    drain();

    // Fill past capacity, then a push that rides on a pop while full.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 300 + i, i, 0, 0);
    check("full_level", level, 16);
    check("full_ovf", overflowCount, 4);
    cyc(1, 999, 8'h55, 0, 1);
    check("full_pop_level", level, 16);
    check("full_pop_ovf", overflowCount, 4);
    // Trailer waits while full; corners during the wait are dropped.
    cyc(0, 0, 0, 1, 0);
    cyc(1, 500, 1, 0, 0);
    cyc(1, 501, 2, 0, 0);
    check("pend_ovf", overflowCount, 6);
    drain();

    // frameEnd together with a corner, then a corner right after.
    cyc(1, 77, 8'h11, 1, 0);
    check("same_cycle_head", {outValid, outLast, outAddr}, {2'b10, 17'd77});
    cyc(1, 78, 8'h22, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 4) begin
        do_reset();
      end else begin
        cyc($urandom_range(99) < 55, $urandom_range(FC_MAX), $urandom_range(255),
            $urandom_range(99) < 6, $urandom_range(99) < 55);
      end
    end
    cyc(0, 0, 0, 1, 1);
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
